// File: rtl/bcd_stopwatch_if.sv
// Button inputs and BCD digit outputs of the stopwatch, grouped for the ports.
// With BCD_STOPWATCH_COUNTDOWN_EN defined the count-direction input `down` is present.
interface bcd_stopwatch_if;
    logic       btn_start;
    logic       btn_clr;
`ifdef BCD_STOPWATCH_COUNTDOWN_EN
    logic       down;
`endif
    logic [3:0] data0;
    logic [3:0] data1;
    logic [3:0] data2;
    logic [3:0] data3;
    logic       running;
    logic       ovf;

`ifdef BCD_STOPWATCH_COUNTDOWN_EN
    modport master (output btn_start, btn_clr, down,
                    input  data0, data1, data2, data3, running, ovf);
    modport slave  (input  btn_start, btn_clr, down,
                    output data0, data1, data2, data3, running, ovf);
`else
    modport master (output btn_start, btn_clr,
                    input  data0, data1, data2, data3, running, ovf);
    modport slave  (input  btn_start, btn_clr,
                    output data0, data1, data2, data3, running, ovf);
`endif
endinterface

// File: rtl/bcd_stopwatch.sv
// 4-digit BCD stopwatch with synchronised start/pause and clear buttons.
// Optional feature macro: BCD_STOPWATCH_COUNTDOWN_EN (adds BCD down-count via `down`).
module bcd_stopwatch #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TICK_HZ     = 100,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    bcd_stopwatch_if.slave sw
);
    localparam int            DIV        = CLK_HZ / TICK_HZ;
    localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

    logic [SYNC_STAGES-1:0] start_sync_q, clr_sync_q;
    logic                   start_edge_q, clr_edge_q;
    logic                   start_pulse, clr_pulse;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [3:0][3:0] digit_q, digit_d;
    logic            ovf_q, ovf_d;
    logic            running_q;
    logic            tick;
    logic            carry;
    logic            count_down;

`ifdef BCD_STOPWATCH_COUNTDOWN_EN
    assign count_down = sw.down;
`else
    assign count_down = 1'b0;
`endif

    // Pulse lasts exactly one cycle: the edge flop catches up on the next clock.
    assign start_pulse = start_sync_q[SYNC_STAGES-1] & ~start_edge_q;
    assign clr_pulse   = clr_sync_q[SYNC_STAGES-1]   & ~clr_edge_q;

    // NOTE: every flop, including the digit array, is async-reset so an abort
    // mid-count leaves no partial state; sequential state uses <= only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            start_sync_q <= '0;
            clr_sync_q   <= '0;
            start_edge_q <= 1'b0;
            clr_edge_q   <= 1'b0;
            state_q      <= IDLE;
            presc_q      <= '0;
            digit_q      <= '0;
            ovf_q        <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], sw.btn_start};
            clr_sync_q   <= {clr_sync_q[SYNC_STAGES-2:0], sw.btn_clr};
            start_edge_q <= start_sync_q[SYNC_STAGES-1];
            clr_edge_q   <= clr_sync_q[SYNC_STAGES-1];
            state_q      <= state_d;
            presc_q      <= presc_d;
            digit_q      <= digit_d;
            ovf_q        <= ovf_d;
            running_q    <= (state_d == RUN);
        end
    end

    // NOTE: all outputs of this block get a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        digit_d = digit_q;
        ovf_d   = ovf_q;
        tick    = 1'b0;
        carry   = 1'b1;

        if (clr_pulse) begin
            state_d = IDLE;
            presc_d = '0;
            digit_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (start_pulse) begin
                case (state_q)
                    IDLE:    state_d = RUN;
                    RUN:     state_d = PAUSE;
                    PAUSE:   state_d = RUN;
                    default: state_d = IDLE;
                endcase
            end

            case (state_q)
                RUN: begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        tick    = 1'b1;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSE:   presc_d = presc_q;
                default: presc_d = '0;
            endcase

            // Ripple carry/borrow: each digit only moves while the lower ones wrapped.
            if (tick) begin
                for (int i = 0; i < 4; i++) begin
                    if (carry) begin
                        if (count_down) begin
                            if (digit_q[i] == 4'd0) digit_d[i] = 4'd9;
                            else begin
                                digit_d[i] = digit_q[i] - 4'd1;
                                carry      = 1'b0;
                            end
                        end else begin
                            if (digit_q[i] == 4'd9) digit_d[i] = 4'd0;
                            else begin
                                digit_d[i] = digit_q[i] + 4'd1;
                                carry      = 1'b0;
                            end
                        end
                    end
                end
                if (carry) ovf_d = 1'b1;
            end
        end
    end

    assign sw.data0   = digit_q[0];
    assign sw.data1   = digit_q[1];
    assign sw.data2   = digit_q[2];
    assign sw.data3   = digit_q[3];
    assign sw.running = running_q;
    assign sw.ovf     = ovf_q;
endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench: a 10-cycle-tick instance for timing/pause/reset/clear and a
// 2-cycle-tick instance for carry, 9999 wrap and (when enabled) countdown.
module tb_bcd_stopwatch;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    bcd_stopwatch_if if_a ();
    bcd_stopwatch_if if_b ();

    bcd_stopwatch #(.CLK_HZ(100), .TICK_HZ(10), .SYNC_STAGES(2)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .sw    (if_a.slave)
    );

    bcd_stopwatch #(.CLK_HZ(20), .TICK_HZ(10), .SYNC_STAGES(2)) u_wrap (
        .clk_i (clk),
        .rst_i (rst),
        .sw    (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] data_a();
        return {if_a.data3, if_a.data2, if_a.data1, if_a.data0};
    endfunction

    function automatic logic [15:0] data_b();
        return {if_b.data3, if_b.data2, if_b.data1, if_b.data0};
    endfunction

    task automatic press_a(input logic start, input logic clr);
        if_a.btn_start = start;
        if_a.btn_clr   = clr;
        cycles(3);
        if_a.btn_start = 1'b0;
        if_a.btn_clr   = 1'b0;
    endtask

    task automatic press_b(input logic start, input logic clr);
        if_b.btn_start = start;
        if_b.btn_clr   = clr;
        cycles(3);
        if_b.btn_start = 1'b0;
        if_b.btn_clr   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        if_a.btn_start = 1'b0; if_a.btn_clr = 1'b0;
        if_b.btn_start = 1'b0; if_b.btn_clr = 1'b0;
`ifdef BCD_STOPWATCH_COUNTDOWN_EN
        if_a.down = 1'b0;
        if_b.down = 1'b0;
`endif
        cycles(3);
        check("reset_data", 32'(data_a()), 32'h0);
        check("reset_running", 32'(if_a.running), 32'h0);
        check("reset_ovf", 32'(if_a.ovf), 32'h0);
        rst = 1'b0;
        cycles(3);

        // Run: RUNNING rises on the third edge after the press; 25 ticks in 250 cycles.
        if_a.btn_start = 1'b1;
        cycles(2);
        check("run_not_yet", 32'(if_a.running), 32'h0);
        cycles(1);
        check("run_after_3", 32'(if_a.running), 32'h1);
        if_a.btn_start = 1'b0;
        cycles(250);
        check("run_250", 32'(data_a()), 32'h0025);

        // Pause with prescaler at 3; resume must tick after 7 cycles, not 10.
        press_a(1'b1, 1'b0);
        check("pause_running", 32'(if_a.running), 32'h0);
        cycles(500);
        check("pause_hold", 32'(data_a()), 32'h0025);
        press_a(1'b1, 1'b0);
        check("resume_running", 32'(if_a.running), 32'h1);
        cycles(6);
        check("resume_before", 32'(data_a()), 32'h0025);
        cycles(1);
        check("resume_tick", 32'(data_a()), 32'h0026);
        cycles(160);
        check("run_to_42", 32'(data_a()), 32'h0042);

        // Async reset mid-count takes effect without a clock edge.
        rst = 1'b1;
        #1;
        check("rst_mid_data", 32'(data_a()), 32'h0);
        check("rst_mid_running", 32'(if_a.running), 32'h0);
        check("rst_mid_ovf", 32'(if_a.ovf), 32'h0);
        cycles(2);
        rst = 1'b0;
        cycles(30);
        check("rst_stays_idle", 32'({if_a.running, data_a()}), 32'h0);

        // Clear beats start when both rise together.
        press_a(1'b1, 1'b0);
        cycles(30);
        check("pre_clr_data", 32'(data_a()), 32'h0003);
        press_a(1'b1, 1'b1);
        check("clr_prio_data", 32'(data_a()), 32'h0);
        check("clr_prio_running", 32'(if_a.running), 32'h0);
        cycles(30);
        check("clr_prio_idle", 32'({if_a.running, data_a()}), 32'h0);

        // Carry and wrap on the fast instance: one tick every 2 cycles.
        press_b(1'b1, 1'b0);
        check("b_running", 32'(if_b.running), 32'h1);
        cycles(198);
        check("b_0099", 32'(data_b()), 32'h0099);
        cycles(2);
        check("b_0100", 32'(data_b()), 32'h0100);
        cycles(19798);
        check("b_9999", 32'({if_b.ovf, data_b()}), 32'h0_9999);
        cycles(2);
        check("b_wrap", 32'({if_b.ovf, data_b()}), 32'h1_0000);
        cycles(40);
        check("b_ovf_sticky", 32'({if_b.ovf, data_b()}), 32'h1_0020);
        press_b(1'b1, 1'b1);
        check("b_clr_all", 32'({if_b.running, if_b.ovf, data_b()}), 32'h0);
        cycles(20);
        check("b_clr_idle", 32'({if_b.running, data_b()}), 32'h0);

`ifdef BCD_STOPWATCH_COUNTDOWN_EN
        if_b.down = 1'b1;
        press_b(1'b1, 1'b0);
        cycles(2);
        check("dn_wrap", 32'({if_b.ovf, data_b()}), 32'h1_9999);
        cycles(19798);
        check("dn_0100", 32'(data_b()), 32'h0100);
        cycles(2);
        check("dn_0099", 32'(data_b()), 32'h0099);
        cycles(2);
        check("dn_0098", 32'(data_b()), 32'h0098);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
